// File: rtl/sram_pkg.sv
// Shared constants for the predictor SRAM macros: geometry and the three word widths in use.
package sram_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 1024;

   localparam int unsigned BIPC_W = 28;
   localparam int unsigned PHT_W  = 2;
   localparam int unsigned BTB_W  = 40;

endpackage

// File: rtl/sram_port_ctrl.sv
// Decodes one port's active-low macro controls into a read strobe, a write strobe and a per-bit write mask.
module sram_port_ctrl #(
   parameter int unsigned DATA_W = sram_pkg::BIPC_W
) (
   input  logic              en,
   input  logic              ceb,
   input  logic              web,
   input  logic [DATA_W-1:0] bweb,
   output logic              rd_c,
   output logic              wr_c,
   output logic [DATA_W-1:0] wmask_c
);
   import sram_pkg::*;

   // en drops during reset so the port neither reads nor writes
   always_comb begin
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      wmask_c = '0;
      if (en && !ceb) begin
         rd_c = web;
         wr_c = !web;
      end
      if (wr_c) begin
         wmask_c = ~bweb;
      end
   end

endmodule

// File: rtl/dp_sram_1024.sv
// True dual-port synchronous SRAM model, read-before-write, port A wins on dual-write collisions.
// Define SRAM_INIT_EN to fill the array with INIT_VAL at time zero (simulation only).
module dp_sram_1024 #(
   parameter int unsigned       DATA_W   = sram_pkg::BIPC_W,
   parameter int unsigned       ADDR_W   = sram_pkg::ADDR_W,
   parameter int unsigned       DEPTH    = sram_pkg::DEPTH,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] AA,
   input  logic [DATA_W-1:0] DA,
   input  logic [DATA_W-1:0] BWEBA,
   input  logic              WEBA,
   input  logic              CEBA,
   output logic [DATA_W-1:0] QA,
   input  logic [ADDR_W-1:0] AB,
   input  logic [DATA_W-1:0] DB,
   input  logic [DATA_W-1:0] BWEBB,
   input  logic              WEBB,
   input  logic              CEBB,
   output logic [DATA_W-1:0] QB
);
   import sram_pkg::*;

   if ((DEPTH != (32'd1 << ADDR_W)) || ($bits(INIT_VAL) != DATA_W)) begin : g_cfg_chk
      $error("dp_sram_1024: DEPTH must equal 2**ADDR_W and INIT_VAL must be DATA_W wide");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              rd_a_c, wr_a_c, rd_b_c, wr_b_c;
   logic [DATA_W-1:0] wmask_a_c, wmask_b_c;
   logic              same_addr_c, wr_b_eff_c;
   logic [DATA_W-1:0] b_into_a_c, wdata_a_c, wdata_b_c;
   logic [DATA_W-1:0] qa_d, qa_q, qb_d, qb_q;

   sram_port_ctrl #(.DATA_W(DATA_W)) u_ctrl_a (
      .en      (rst),
      .ceb     (CEBA),
      .web     (WEBA),
      .bweb    (BWEBA),
      .rd_c    (rd_a_c),
      .wr_c    (wr_a_c),
      .wmask_c (wmask_a_c)
   );

   sram_port_ctrl #(.DATA_W(DATA_W)) u_ctrl_b (
      .en      (rst),
      .ceb     (CEBB),
      .web     (WEBB),
      .bweb    (BWEBB),
      .rd_c    (rd_b_c),
      .wr_c    (wr_b_c),
      .wmask_c (wmask_b_c)
   );

   // On a same-address dual write, B's bits are folded into A's word where A leaves them unmasked
   always_comb begin
      same_addr_c = (AA == AB);
      b_into_a_c  = '0;
      if (wr_a_c && wr_b_c && same_addr_c) begin
         b_into_a_c = wmask_b_c & ~wmask_a_c;
      end
      wr_b_eff_c = wr_b_c && !(wr_a_c && same_addr_c);
      wdata_a_c  = (mem_q[AA] & ~(wmask_a_c | b_into_a_c)) | (DA & wmask_a_c) | (DB & b_into_a_c);
      wdata_b_c  = (mem_q[AB] & ~wmask_b_c) | (DB & wmask_b_c);
   end

   // Read data sampled from the pre-edge array contents, which gives read-before-write
   always_comb begin
      qa_d = qa_q;
      qb_d = qb_q;
      if (!rst) begin
         qa_d = '0;
         qb_d = '0;
      end else begin
         if (rd_a_c) qa_d = mem_q[AA];
         if (rd_b_c) qb_d = mem_q[AB];
      end
   end

   always_ff @(posedge clk) begin
      qa_q <= qa_d;
      qb_q <= qb_d;
   end

   always_ff @(posedge clk) begin
      if (wr_a_c)     mem_q[AA] <= wdata_a_c;
      if (wr_b_eff_c) mem_q[AB] <= wdata_b_c;
   end

`ifdef SRAM_INIT_EN
   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] = INIT_VAL;
   end
`endif

   assign QA = qa_q;
   assign QB = qb_q;

endmodule

// File: tb/tb_dp_sram_1024.sv
// Directed scoreboard bench for dp_sram_1024 at DATA_W=28.
`timescale 1ns/1ps
module tb_dp_sram_1024;

   logic        clk;
   logic        rst;
   logic [9:0]  AA, AB;
   logic [27:0] DA, DB, BWEBA, BWEBB, QA, QB;
   logic        WEBA, CEBA, WEBB, CEBB;

   int tests_run = 0;
   int tests_failed = 0;

   logic [27:0] exp_a [$];
   logic [27:0] exp_b [$];

   dp_sram_1024 #(.DATA_W(28), .ADDR_W(10), .DEPTH(1024)) dut (
      .clk   (clk),
      .rst   (rst),
      .AA    (AA),
      .DA    (DA),
      .BWEBA (BWEBA),
      .WEBA  (WEBA),
      .CEBA  (CEBA),
      .QA    (QA),
      .AB    (AB),
      .DB    (DB),
      .BWEBB (BWEBB),
      .WEBB  (WEBB),
      .CEBB  (CEBB),
      .QB    (QB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_a(input string tag);
      if (exp_a.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL %s: observed empty port A scoreboard expected entry", tag);
      end else begin
         chk(tag, QA, exp_a.pop_front());
      end
   endtask

   task automatic pop_b(input string tag);
      if (exp_b.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL %s: observed empty port B scoreboard expected entry", tag);
      end else begin
         chk(tag, QB, exp_b.pop_front());
      end
   endtask

   task automatic idle_a();
      CEBA = 1'b1; WEBA = 1'b1; BWEBA = '1; DA = '0;
   endtask

   task automatic idle_b();
      CEBB = 1'b1; WEBB = 1'b1; BWEBB = '1; DB = '0;
   endtask

   task automatic set_wr_a(input logic [9:0] a, input logic [27:0] d, input logic [27:0] bw);
      AA = a; DA = d; BWEBA = bw; WEBA = 1'b0; CEBA = 1'b0;
   endtask

   task automatic set_wr_b(input logic [9:0] a, input logic [27:0] d, input logic [27:0] bw);
      AB = a; DB = d; BWEBB = bw; WEBB = 1'b0; CEBB = 1'b0;
   endtask

   task automatic wr_a(input logic [9:0] a, input logic [27:0] d, input logic [27:0] bw);
      set_wr_a(a, d, bw);
      tick();
      idle_a();
   endtask

   task automatic rd_a(input string tag, input logic [9:0] a, input logic [27:0] exp);
      AA = a; WEBA = 1'b1; CEBA = 1'b0;
      exp_a.push_back(exp);
      tick();
      idle_a();
      pop_a(tag);
   endtask

   task automatic rd_b(input string tag, input logic [9:0] a, input logic [27:0] exp);
      AB = a; WEBB = 1'b1; CEBB = 1'b0;
      exp_b.push_back(exp);
      tick();
      idle_b();
      pop_b(tag);
   endtask

   initial begin
      AA = '0; AB = '0;
      idle_a();
      idle_b();

      // Reset from time zero with port B attempting reads
      rst = 1'b0;
      CEBB = 1'b0;
      tick();
      tick();
      chk("rst_qa", QA, 28'h0);
      chk("rst_qb", QB, 28'h0);
      idle_b();
      rst = 1'b1;

      // Array survives reset; writes and reads are blocked during reset
      wr_a(10'h009, 28'h0ABCDEF, '0);
      rd_b("pre_rst_rd9", 10'h009, 28'h0ABCDEF);
      rst = 1'b0;
      set_wr_a(10'h009, 28'h7777777, '0);
      AB = 10'h009; WEBB = 1'b1; CEBB = 1'b0;
      tick();
      tick();
      chk("rst2_qa", QA, 28'h0);
      chk("rst2_qb", QB, 28'h0);
      idle_a();
      idle_b();
      rst = 1'b1;
      rd_b("post_rst_rd9", 10'h009, 28'h0ABCDEF);

      // Basic write then read on both ports
      wr_a(10'h005, 28'h1234567, '0);
      rd_b("basic_rd_b", 10'h005, 28'h1234567);
      rd_a("basic_rd_a", 10'h005, 28'h1234567);

      // Bit-write masks on each port
      wr_a(10'h005, 28'hFFFFFFF, 28'hFFFFFF0);
      rd_b("mask_a", 10'h005, 28'h123456F);
      set_wr_b(10'h005, 28'h0000000, 28'hFFFFF0F);
      tick();
      idle_b();
      rd_a("mask_b", 10'h005, 28'h123450F);

      // A writes / B reads same address: old data returned, write lands
      wr_a(10'h007, 28'hAAAAAAA, '0);
      set_wr_a(10'h007, 28'h5555555, '0);
      AB = 10'h007; WEBB = 1'b1; CEBB = 1'b0;
      exp_b.push_back(28'hAAAAAAA);
      tick();
      idle_a();
      idle_b();
      pop_b("coll_old_b");
      rd_b("coll_new_b", 10'h007, 28'h5555555);

      // B writes / A reads same address; QB holds across its own write
      set_wr_b(10'h007, 28'h0F0F0F0, '0);
      AA = 10'h007; WEBA = 1'b1; CEBA = 1'b0;
      exp_a.push_back(28'h5555555);
      tick();
      idle_a();
      idle_b();
      pop_a("coll_old_a");
      chk("no_wt_qb", QB, 28'h5555555);
      rd_a("coll_new_a", 10'h007, 28'h0F0F0F0);

      // Disabled ports: output holds, write with CEB high does nothing
      AB = 10'h3FF; WEBB = 1'b1; CEBB = 1'b1;
      tick();
      tick();
      chk("ceb_hold_qb", QB, 28'h5555555);
      AA = 10'h007; DA = 28'h0001234; BWEBA = '0; WEBA = 1'b0; CEBA = 1'b1;
      tick();
      idle_a();
      rd_b("ceb_nowrite", 10'h007, 28'h0F0F0F0);

      // Dual write to one address: A wins, B fills A-masked bits
      set_wr_a(10'h003, 28'h0000001, '0);
      set_wr_b(10'h003, 28'h0000002, '0);
      tick();
      idle_a();
      idle_b();
      rd_b("dual_wr_full", 10'h003, 28'h0000001);
      set_wr_a(10'h003, 28'hFFFFFFF, 28'hFFFFFF0);
      set_wr_b(10'h003, 28'h0000000, '0);
      tick();
      idle_a();
      idle_b();
      rd_a("dual_wr_mask", 10'h003, 28'h000000F);

      // Address extremes with back-to-back pipelined reads
      wr_a(10'h000, 28'h1111111, '0);
      wr_a(10'h3FF, 28'h2222222, '0);
      AB = 10'h000; WEBB = 1'b1; CEBB = 1'b0;
      exp_b.push_back(28'h1111111);
      tick();
      AB = 10'h3FF;
      exp_b.push_back(28'h2222222);
      pop_b("pipe_rd_0");
      tick();
      idle_b();
      pop_b("pipe_rd_3ff");
      tick();
      chk("pipe_hold", QB, 28'h2222222);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dp_sram_1024.md
Name: dp_sram_1024

Overview:
- Behavioural model of a 1024-entry, true dual-port synchronous SRAM macro (ports A and B).
- Each port has its own address, data-in, write-enable, bit-write-enable and chip-enable; all are active-low, matching foundry macro conventions.
- One parameterised module covers the three macro widths in use: 28-bit (branch-PC tags), 2-bit (pattern history) and 40-bit (branch targets).
- Predictor memories use port A as the write port and port B as the read port.

Parameters:
- DATA_W, 28, word width in bits; instantiated as 28, 2 and 40.
- ADDR_W, 10, address width.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.
- INIT_VAL, all-zeros, power-up fill value; used only with SRAM_INIT_EN.

Ports:
- clk  in  1  clock for both ports. Replaces macro pins CLKA/CLKB.
- rst  in  1  synchronous active-low reset.
- AA  in  ADDR_W  port A address.
- DA  in  DATA_W  port A write data.
- BWEBA  in  DATA_W  port A bit-write enable, active-low per bit.
- WEBA  in  1  port A write enable, active-low.
- CEBA  in  1  port A chip enable, active-low.
- QA  out  DATA_W  port A registered read data.
- AB  in  ADDR_W  port B address.
- DB  in  DATA_W  port B write data.
- BWEBB  in  DATA_W  port B bit-write enable, active-low per bit.
- WEBB  in  1  port B write enable, active-low.
- CEBB  in  1  port B chip enable, active-low.
- QB  out  DATA_W  port B registered read data.

Behaviour:
- All actions occur on the rising edge of clk.
- Reset:
  - rst=0 forces QA=0 and QB=0 on the next edge.
  - Array contents are not altered by reset.
  - No read or write is performed while rst=0.
- Port p disabled (CEBp=1): no access; Qp holds its value.
- Port p read (CEBp=0, WEBp=1):
  - Qp <= mem[Ap] at the edge; latency 1 cycle.
  - Qp holds until the port's next read.
- Port p write (CEBp=0, WEBp=0):
  - For each bit i with BWEBp[i]=0, mem[Ap][i] <= Dp[i]; bits with BWEBp[i]=1 keep their old value.
  - Qp holds during a write (no write-through).
- Collision, one port reads and the other writes the same address in the same cycle:
  - The read returns the old contents (read-before-write).
  - The write still completes.
  - Callers add their own bypass to obtain new data.
- Collision, both ports write the same address: port A's enabled bits take priority; port B's bits are applied only where BWEBA[i]=1.
- Out-of-range addresses cannot occur (DEPTH=2**ADDR_W); no wrap logic is needed.
- The outputs are the only state besides the array; there is no FSM.

Optional Feature:
- Macro: SRAM_INIT_EN.
- When defined: at time zero every word is filled with INIT_VAL (simulation initialisation). Predictor instances use 28'hFFFFFFF (tag), 2'b00 (PHT) and 40'h0 (BTB).
- When undefined: no initial block; contents are undefined (X) until written; the model is synthesizable as plain registers.

Decomposition:
- Shared package sram_pkg holds:
  - ADDR_W=10 and DEPTH=1024;
  - width constants BIPC_W=28, PHT_W=2 and BTB_W=40.
- One natural sub-module, sram_port_ctrl, instanced twice (A, B). It decodes CEB/WEB/BWEB into a read strobe and a per-bit write mask.
- The array, collision priority and output registers live in the top.

Test Plan (DATA_W=28):
1. Reset: hold rst=0 for 2 cycles with port B reading -> QA=QB=0; array unchanged after release.
2. Basic write/read: port A writes AA=10'h005, DA=28'h1234567, BWEBA=0; next cycle port B reads AB=5 -> QB=28'h1234567 one edge later.
3. Bit mask: word 5 holds 28'h1234567; write DA=28'hFFFFFFF with BWEBA=28'hFFFFFF0 -> reading 5 returns 28'h123456F.
4. Read/write collision: word 7 holds 28'hAAAAAAA; same cycle A writes 28'h5555555 to 7 and B reads 7 -> QB=28'hAAAAAAA; next read of 7 -> 28'h5555555.
5. Chip-enable hold: after QB=28'h5555555, set CEBB=1 and change AB -> QB stays 28'h5555555; WEBA=0 with CEBA=1 writes nothing.
6. Dual write same address: A writes 28'h0000001 and B writes 28'h0000002 to 3, both BWEB=0 -> read of 3 returns 28'h0000001.
